// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the exception-unit FSM encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_RI  = 5'h0A;
  localparam logic [4:0] EXC_OV  = 5'h0C;

  localparam int unsigned ST_IE_BIT   = 0;
  localparam int unsigned ST_EXL_BIT  = 1;
  localparam int unsigned ST_IM_LSB   = 8;
  localparam int unsigned CA_BD_BIT   = 31;
  localparam int unsigned CA_IP_LSB   = 8;
  localparam int unsigned CA_CODE_LSB = 2;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 exception unit signal bundle.
interface cp0_exc_unit_if;
  // No valid/ready pair here: id_valid marks a real ID instruction (it only
  // gates interrupts), and exc_take is a one-cycle flush strobe with no
  // acknowledge -- the pipeline must squash and redirect in that same cycle.
  logic [31:0] id_pc;
  logic        id_bd;
  logic        id_valid;
  logic        id_syscall;
  logic        id_unknown;
  logic        id_eret;
  logic [31:0] exe_pc;
  logic        exe_bd;
  logic        exe_overflow;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_take;
  logic [31:0] redirect_pc;

  modport master (
    output id_pc, id_bd, id_valid, id_syscall, id_unknown, id_eret,
    output exe_pc, exe_bd, exe_overflow,
    output mtc0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, exc_take, redirect_pc
  );

  modport slave (
    input  id_pc, id_bd, id_valid, id_syscall, id_unknown, id_eret,
    input  exe_pc, exe_bd, exe_overflow,
    input  mtc0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, exc_take, redirect_pc
  );
endinterface

// File: rtl/cp0_exc_unit_int_sync.sv
// Multi-flop synchroniser for asynchronous level-sensitive interrupt lines.
module int_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: STATUS/CAUSE/EPC, age-ordered exception arbitration,
// pipeline flush/redirect, mtc0/mfc0 and eret.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT  = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_HW_INT-1:0] hw_int,
  cp0_exc_unit_if.slave         bus,
  output logic [31:0]           status_q,
  output logic [31:0]           cause_q,
  output logic [31:0]           epc_q,
  output cp0_state_e            dbg_state_o
);

  cp0_state_e state_q, state_d;
  logic       ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
  logic [7:0] im_q, im_d;
  logic [1:0] sw_ip_q, sw_ip_d;
  logic [4:0] code_q, code_d;
  logic [31:0] epc_d;

  logic [NUM_HW_INT-1:0] hw_sync;
  logic [7:0]  ip_vec;
  logic        int_pend, exc_any;
  logic [4:0]  sel_code;
  logic [31:0] sel_pc;
  logic        sel_bd;
  logic        exc_take;
  logic [31:0] redirect_pc;

  int_sync #(.W(NUM_HW_INT), .STAGES(SYNC_STAGES)) u_hw_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (hw_int),
    .q_o  (hw_sync)
  );

  // Hardware IP bits are the synchroniser output itself, so no extra cycle.
  always_comb begin
    ip_vec = '0;
    ip_vec[1:0] = sw_ip_q;
    ip_vec[NUM_HW_INT+1:2] = hw_sync;
  end

  always_comb begin
    status_q = '0;
    status_q[ST_IE_BIT]  = ie_q;
    status_q[ST_EXL_BIT] = exl_q;
    status_q[ST_IM_LSB +: 8] = im_q;
    cause_q = '0;
    cause_q[CA_BD_BIT]         = bd_q;
    cause_q[CA_IP_LSB +: 8]    = ip_vec;
    cause_q[CA_CODE_LSB +: 5]  = code_q;
  end

  assign int_pend = ie_q & ~exl_q & (|(ip_vec & im_q)) & bus.id_valid;
  assign exc_any  = bus.exe_overflow | bus.id_unknown | bus.id_syscall | int_pend;

  // EXE is the older instruction, so its overflow beats anything in ID.
  always_comb begin
    sel_code = EXC_INT;
    sel_pc   = bus.id_pc;
    sel_bd   = bus.id_bd;
    if (bus.exe_overflow) begin
      sel_code = EXC_OV;
      sel_pc   = bus.exe_pc;
      sel_bd   = bus.exe_bd;
    end else if (bus.id_unknown) begin
      sel_code = EXC_RI;
    end else if (bus.id_syscall) begin
      sel_code = EXC_SYS;
    end
  end

  always_comb begin
    state_d     = state_q;
    ie_d        = ie_q;
    exl_d       = exl_q;
    im_d        = im_q;
    sw_ip_d     = sw_ip_q;
    bd_d        = bd_q;
    code_d      = code_q;
    epc_d       = epc_q;
    exc_take    = 1'b0;
    redirect_pc = EXC_VECTOR;

    if (bus.mtc0_we) begin
      case (bus.cp0_addr)
        CP0_STATUS: begin
          ie_d  = bus.cp0_wdata[ST_IE_BIT];
          exl_d = bus.cp0_wdata[ST_EXL_BIT];
          im_d  = bus.cp0_wdata[ST_IM_LSB +: 8];
        end
        CP0_CAUSE: sw_ip_d = bus.cp0_wdata[CA_IP_LSB +: 2];
        CP0_EPC:   epc_d   = bus.cp0_wdata;
        default: ;
      endcase
    end

    // Exception/eret field updates are applied after mtc0 so they take priority.
    case (state_q)
      S_RUN: begin
        if (exc_any) begin
          exc_take = 1'b1;
          code_d   = sel_code;
          if (!exl_q) begin
            epc_d = sel_bd ? (sel_pc - 32'd4) : sel_pc;
            bd_d  = sel_bd;
            exl_d = 1'b1;
          end
          state_d = S_FLUSH;
        end else if (bus.id_eret) begin
          exc_take    = 1'b1;
          redirect_pc = epc_q;
          exl_d       = 1'b0;
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ie_q    <= 1'b0;
      exl_q   <= 1'b1;
      im_q    <= '0;
      sw_ip_q <= '0;
      bd_q    <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      sw_ip_q <= sw_ip_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    case (bus.cp0_addr)
      CP0_STATUS: bus.cp0_rdata = status_q;
      CP0_CAUSE:  bus.cp0_rdata = cause_q;
      CP0_EPC:    bus.cp0_rdata = epc_q;
      default:    bus.cp0_rdata = '0;
    endcase
  end

  assign bus.exc_take    = exc_take;
  assign bus.redirect_pc = redirect_pc;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed table-driven bench for cp0_exc_unit, plus a mid-operation reset sequence.
module tb_cp0_exc_unit;
  import cp0_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] hw_int;
  logic [31:0] status_q, cause_q, epc_q;
  cp0_state_e  dbg_state;

  cp0_exc_unit_if bus();

  cp0_exc_unit #(.NUM_HW_INT(6), .SYNC_STAGES(2), .EXC_VECTOR(32'h0000_0180)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hw_int     (hw_int),
    .bus        (bus),
    .status_q   (status_q),
    .cause_q    (cause_q),
    .epc_q      (epc_q),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  hw;
    logic        iv;
    logic [31:0] ipc;
    logic        ibd, sys, ri, er;
    logic [31:0] xpc;
    logic        xbd, ov, we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        take;
    logic [31:0] redir, rdata, st, ca, ep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    logic [5:0] hw, logic iv, logic [31:0] ipc, logic ibd, logic sys, logic ri, logic er,
    logic [31:0] xpc, logic xbd, logic ov, logic we, logic [4:0] addr, logic [31:0] wd,
    logic take, logic [31:0] redir, logic [31:0] rdata,
    logic [31:0] st, logic [31:0] ca, logic [31:0] ep);
    vec_t v;
    v.hw = hw; v.iv = iv; v.ipc = ipc; v.ibd = ibd; v.sys = sys; v.ri = ri; v.er = er;
    v.xpc = xpc; v.xbd = xbd; v.ov = ov; v.we = we; v.addr = addr; v.wd = wd;
    v.take = take; v.redir = redir; v.rdata = rdata; v.st = st; v.ca = ca; v.ep = ep;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    hw_int = '0;
    bus.id_pc = '0; bus.id_bd = 1'b0; bus.id_valid = 1'b0;
    bus.id_syscall = 1'b0; bus.id_unknown = 1'b0; bus.id_eret = 1'b0;
    bus.exe_pc = '0; bus.exe_bd = 1'b0; bus.exe_overflow = 1'b0;
    bus.mtc0_we = 1'b0; bus.cp0_addr = '0; bus.cp0_wdata = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    hw_int = v.hw;
    bus.id_valid = v.iv; bus.id_pc = v.ipc; bus.id_bd = v.ibd;
    bus.id_syscall = v.sys; bus.id_unknown = v.ri; bus.id_eret = v.er;
    bus.exe_pc = v.xpc; bus.exe_bd = v.xbd; bus.exe_overflow = v.ov;
    bus.mtc0_we = v.we; bus.cp0_addr = v.addr; bus.cp0_wdata = v.wd;
    #1;
    chk($sformatf("v%0d exc_take", idx), {31'b0, bus.exc_take}, {31'b0, v.take});
    if (v.take) chk($sformatf("v%0d redirect_pc", idx), bus.redirect_pc, v.redir);
    chk($sformatf("v%0d cp0_rdata", idx), bus.cp0_rdata, v.rdata);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d status", idx), status_q, v.st);
    chk($sformatf("v%0d cause", idx), cause_q, v.ca);
    chk($sformatf("v%0d epc", idx), epc_q, v.ep);
    chk($sformatf("v%0d state", idx), {31'b0, dbg_state},
        {31'b0, v.take ? S_FLUSH : S_RUN});
  endtask

  initial begin
    //   hw iv ipc     ibd sys ri er xpc     xbd ov we addr wd            take redir    rdata         status    cause         epc
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 12, 32'h401,      0,   0,       32'h2,        32'h401,  32'h0,        32'h0);
    add(1, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h0,        32'h401,  32'h0,        32'h0);
    add(1, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h0,        32'h401,  32'h400,      32'h0);
    add(1, 1, 32'h100,0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            1,   32'h180, 32'h400,      32'h403,  32'h400,      32'h100);
    add(1, 1, 32'h104,0,  0,  0, 0, 0,      0,  0, 0, 12, 0,            0,   0,       32'h403,      32'h403,  32'h400,      32'h100);
    add(0, 1, 32'h104,0,  0,  0, 1, 0,      0,  0, 0, 14, 0,            1,   32'h100, 32'h100,      32'h401,  32'h400,      32'h100);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h400,      32'h401,  32'h0,        32'h100);
    add(0, 0, 0,      0,  0,  0, 0, 32'h204,1,  1, 0, 12, 0,            1,   32'h180, 32'h401,      32'h403,  32'h8000_0030,32'h200);
    add(0, 1, 32'h208,0,  1,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h8000_0030,32'h403,  32'h8000_0030,32'h200);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 12, 0,            0,   0,       32'h403,      32'h0,    32'h8000_0030,32'h200);
    add(0, 1, 32'h304,1,  1,  0, 1, 32'h300,0,  1, 0, 14, 0,            1,   32'h180, 32'h200,      32'h2,    32'h30,       32'h300);
    add(0, 1, 32'h304,1,  1,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h30,       32'h2,    32'h30,       32'h300);
    add(0, 1, 32'h400,1,  0,  1, 0, 0,      0,  0, 0, 14, 0,            1,   32'h180, 32'h300,      32'h2,    32'h28,       32'h300);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h28,       32'h2,    32'h28,       32'h300);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 12, 32'hFF01,     0,   0,       32'h2,        32'hFF01, 32'h28,       32'h300);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 13, 32'hFFFF_FFFF,0,   0,       32'h28,       32'hFF01, 32'h328,      32'h300);
    add(0, 1, 32'h500,0,  1,  0, 0, 0,      0,  0, 1, 12, 32'hAA00,     1,   32'h180, 32'hFF01,     32'hAA02, 32'h320,      32'h500);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 12, 0,            0,   0,       32'hAA02,     32'hAA02, 32'h320,      32'h500);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 14, 32'h600,      0,   0,       32'h500,      32'hAA02, 32'h320,      32'h600);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 5,  32'hFFFF_FFFF,0,   0,       32'h0,        32'hAA02, 32'h320,      32'h600);
    add(0, 1, 32'h504,0,  0,  0, 1, 0,      0,  0, 0, 14, 0,            1,   32'h600, 32'h600,      32'hAA00, 32'h320,      32'h600);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 12, 0,            0,   0,       32'hAA00,     32'hAA00, 32'h320,      32'h600);
    add(0, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 13, 0,            0,   0,       32'h320,      32'hAA00, 32'h20,       32'h600);
    add(1, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 12, 32'h401,      0,   0,       32'hAA00,     32'h401,  32'h20,       32'h600);
    add(1, 0, 0,      0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            0,   0,       32'h20,       32'h401,  32'h420,      32'h600);
    add(1, 1, 32'h700,0,  0,  0, 0, 0,      0,  0, 0, 13, 0,            1,   32'h180, 32'h420,      32'h403,  32'h400,      32'h700);
    add(1, 1, 32'h704,0,  0,  0, 0, 0,      0,  0, 0, 12, 0,            0,   0,       32'h403,      32'h403,  32'h400,      32'h700);
    add(1, 0, 0,      0,  0,  0, 0, 0,      0,  0, 1, 14, 32'h100,      0,   0,       32'h700,      32'h403,  32'h400,      32'h100);
    add(1, 1, 32'h704,0,  0,  0, 1, 0,      0,  0, 0, 14, 0,            1,   32'h100, 32'h100,      32'h401,  32'h400,      32'h100);
    add(1, 1, 32'h708,0,  0,  0, 0, 0,      0,  0, 0, 12, 0,            0,   0,       32'h401,      32'h401,  32'h400,      32'h100);
    add(1, 1, 32'h100,0,  0,  0, 0, 0,      0,  0, 0, 12, 0,            1,   32'h180, 32'h401,      32'h403,  32'h400,      32'h100);

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset status", status_q, 32'h2);
    chk("reset cause", cause_q, 32'h0);
    chk("reset epc", epc_q, 32'h0);
    chk("reset exc_take", {31'b0, bus.exc_take}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset status", status_q, 32'h2);
    chk("post-reset state", {31'b0, dbg_state}, {31'b0, S_RUN});

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Asynchronous reset mid-cycle, then re-check synchroniser latency.
    @(negedge clk);
    drive_idle();
    hw_int = 6'h1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset status", status_q, 32'h2);
    chk("async reset cause", cause_q, 32'h0);
    chk("async reset epc", epc_q, 32'h0);
    chk("async reset state", {31'b0, dbg_state}, {31'b0, S_RUN});
    chk("async reset exc_take", {31'b0, bus.exc_take}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("sync latency 1", cause_q, 32'h0);
    @(posedge clk);
    #1;
    chk("sync latency 2", cause_q, 32'h400);
    chk("sync status held", status_q, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Parametrised CP0 exception unit for the pipelined MIPS core. It owns the STATUS, CAUSE and EPC registers and synchronises external interrupt lines. It arbitrates interrupts, syscall, reserved-instruction and overflow events by pipeline age, and drives the pipeline flush and handler redirect. It also services mtc0/mfc0 and eret. It replaces the purely combinational CAUSE next-value logic with a registered, generalised unit.

## Interface
Parameters:
- NUM_HW_INT, 6: external interrupt lines; map to CAUSE.IP[NUM_HW_INT+1:2] and STATUS.IM[NUM_HW_INT+1:2]; legal range 1..6.
- SYNC_STAGES, 2: flip-flop depth of the hw_int synchroniser; minimum 1.
- EXC_VECTOR, 32'h0000_0180: handler entry address.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hw_int  in  NUM_HW_INT  asynchronous, level-sensitive interrupt requests.
- id_pc  in  32  PC of the ID-stage instruction.
- id_bd  in  1  ID-stage instruction sits in a branch delay slot.
- id_valid  in  1  ID stage holds a real (non-bubble) instruction.
- id_syscall  in  1  syscall decoded in ID.
- id_unknown  in  1  reserved instruction decoded in ID.
- id_eret  in  1  eret decoded in ID.
- exe_pc  in  32  PC of the EXE-stage instruction.
- exe_bd  in  1  EXE-stage instruction sits in a delay slot.
- exe_overflow  in  1  arithmetic overflow in EXE.
- mtc0_we  in  1  CP0 write strobe.
- cp0_addr  in  5  CP0 register number, shared by read and write.
- cp0_wdata  in  32  mtc0 data.
- cp0_rdata  out  32  mfc0 data.
- exc_take  out  1  flush pulse: squash IF/ID/EXE and redirect.
- redirect_pc  out  32  target when exc_take is high: EXC_VECTOR, or EPC for eret.
- status_q, cause_q, epc_q  out  32 each  current register values.

## Operation
- Registers: STATUS(12) has IE=bit0, EXL=bit1, IM=bits[15:8]. CAUSE(13) has BD=bit31, IP=bits[15:8], ExcCode=bits[6:2]. EPC(14) is 32 bits. All other bits read 0.
- CAUSE.IP[NUM_HW_INT+1:2] = synchronised hw_int. These bits are updated every cycle and are not writable. CAUSE.IP[1:0] are software interrupt bits, written by mtc0.
- int_pend = IE & ~EXL & |(IP & IM) & id_valid.
- Event priority, oldest instruction first:
  1. exe_overflow: ExcCode 0x0C; uses exe_pc and exe_bd.
  2. id_unknown: ExcCode 0x0A.
  3. id_syscall: ExcCode 0x08.
  4. int_pend: ExcCode 0x00.
  5. id_eret.
  Codes 2–4 use id_pc and id_bd.
- Taking an exception when EXL=0:
  - EPC = bd ? pc-4 : pc.
  - CAUSE.BD = bd.
  - ExcCode is written.
  - EXL is set to 1.
  - exc_take is raised with redirect_pc = EXC_VECTOR.
- Exception when EXL=1 (nested): ExcCode is updated; EPC, BD and EXL are unchanged; exc_take is still raised.
- eret, when no exception wins: EXL is cleared, exc_take is raised with redirect_pc = epc_q.
- mtc0:
  - Writes only IE, EXL and IM in STATUS; IP[1:0] in CAUSE; all of EPC.
  - Writes to any other address are ignored.
- Two-state FSM:
  - RUN: exc_take is combinational on the current events.
  - FLUSH: entered for one cycle after any exc_take. exc_take is forced low in FLUSH, so squashed bubbles cannot re-trigger. Return to RUN after that cycle.

## Timing
- Reset (asynchronous assert):
  - STATUS, CAUSE and EPC = 0, except STATUS.EXL = 1 (interrupts blocked until software clears it).
  - Synchroniser flops = 0.
  - FSM = RUN.
  - exc_take = 0.
- exc_take and redirect_pc are combinational in the detecting cycle T. Register updates are visible at T+1.
- hw_int-to-IP latency is SYNC_STAGES cycles. The interrupt can be taken in the following cycle.
- cp0_rdata is combinational from the current registers, with no bypass: mfc0 in the same cycle as mtc0 returns the old value.
- mtc0 in the same cycle as an exception: the exception's field updates win, and the remaining written fields still apply.
- exe_overflow together with id_eret: the overflow is taken and the eret is squashed.
- Mid-operation reset: all state returns to reset values on rst_n low, independent of clk.

## Structure
- cp0_pkg:
  - Register numbers (CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14).
  - ExcCode constants (EXC_INT, EXC_SYS, EXC_RI, EXC_OV).
  - Field bit positions.
  - FSM state enum.
- Sub-module int_sync, parametrised by width and SYNC_STAGES; one instance for hw_int.

## Test plan
- Reset: deassert rst_n -> status_q=32'h2, cause_q=0, epc_q=0, exc_take=0.
- Interrupt:
  - Setup: STATUS=32'h0000_0401 via mtc0, then hw_int[0] rises.
  - Required: after 2 cycles, cause_q[10]=1. Next cycle, with id_valid and id_pc=0x100: exc_take=1, redirect_pc=0x180, then epc_q=0x100, ExcCode=0, EXL=1.
- Delay slot: exe_overflow with exe_pc=0x204, exe_bd=1 -> epc_q=0x200, cause_q[31]=1, ExcCode=0x0C.
- Priority: same cycle exe_overflow and id_syscall -> ExcCode=0x0C, exactly one exc_take pulse; in the FLUSH cycle, exc_take=0 even with id_syscall still high.
- Nested: with EXL=1, id_unknown -> ExcCode=0x0A, epc_q unchanged.
- Return: eret with epc_q=0x100 -> redirect_pc=0x100, EXL=0. Then hw_int held high with IE=1 -> interrupt is taken again.
